frame_writer: RTL and testbench



---
 rtl/frame_writer.sv | 163 ++++++++++++++++
 tb/tb_frame_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - packs FIFO pixels into memory words and writes one frame per start
// Optional pixel checksum accumulator: define FRAME_WRITER_CHECKSUM_EN.
module frame_writer #(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int PACK       = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int BASE_ADDR  = 0,
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     fifo_rd_en,
  input  logic [DWIDTH-1:0]        fifo_dout,
  input  logic                     fifo_empty,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [PACK*DWIDTH-1:0]   mem_wdata,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [XW-1:0]            pix_x,
  output logic [YW-1:0]            pix_y,
  output logic [15:0]              checksum
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [LW-1:0]            lane_cnt;
  logic [CW-1:0]            pix_cnt;
  logic [PACK*DWIDTH-1:0]   pack_reg;
  logic                     pop;
  logic                     accept;
  logic                     last_lane;
  logic                     last_pix;
  logic                     frame_full;

  assign pop        = (state == COLLECT) && !fifo_empty;
  assign accept     = (state == WRITE) && mem_ready;
  assign last_lane  = (lane_cnt == LW'(PACK - 1));
  assign last_pix   = (pix_cnt == CW'(TOTAL - 1));
  assign frame_full = (pix_cnt == CW'(TOTAL));
  assign mem_wdata  = pack_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    mem_wr_en  = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        fifo_rd_en = !fifo_empty;
        if (pop && (last_lane || last_pix)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        if (mem_ready) begin
          state_next = frame_full ? DONE : COLLECT;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lanes past the last pixel of a partial word stay zero because the pack
  // register is cleared on every accepted write and on start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_cnt <= '0;
      pix_cnt  <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      pack_reg <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lane_cnt <= '0;
            pix_cnt  <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            pack_reg <= '0;
            mem_addr <= ADDR_WIDTH'(BASE_ADDR);
          end
        end
        COLLECT: begin
          if (pop) begin
            for (int i = 0; i < PACK; i++) begin
              if (lane_cnt == LW'(i)) begin
                pack_reg[i*DWIDTH +: DWIDTH] <= fifo_dout;
              end
            end
            lane_cnt <= lane_cnt + 1'b1;
            pix_cnt  <= pix_cnt + 1'b1;
            if (pix_x == XW'(IMG_WIDTH - 1)) begin
              pix_x <= '0;
              pix_y <= (pix_y == YW'(IMG_HEIGHT - 1)) ? '0 : pix_y + 1'b1;
            end else begin
              pix_x <= pix_x + 1'b1;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            mem_addr <= mem_addr + 1'b1;
            pack_reg <= '0;
            lane_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if ((state == IDLE) && start) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + 16'(fifo_dout);
    end
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer (4x2 and 3x3 instances, PACK=4)
`timescale 1ns/1ps
module tb_frame_writer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int AW = 20;
  localparam int BASE_A = 0;
  localparam int BASE_B = 32'h00100;
`ifdef FRAME_WRITER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: 4x2 frame
  logic          start_a = 1'b0, ready_a = 1'b1;
  logic          rd_a, empty_a, wr_a, busy_a, done_a;
  logic [DW-1:0] dout_a;
  logic [AW-1:0] addr_a;
  logic [31:0]   wdata_a;
  logic [1:0]    px_a;
  logic [0:0]    py_a;
  logic [15:0]   cs_a;

  // Instance B: 3x3 frame, partial last word
  logic          start_b = 1'b0, ready_b = 1'b1, gap_b = 1'b0;
  logic          rd_b, empty_b, wr_b, busy_b, done_b;
  logic [DW-1:0] dout_b;
  logic [AW-1:0] addr_b;
  logic [31:0]   wdata_b;
  logic [1:0]    px_b, py_b;
  logic [15:0]   cs_b;

  frame_writer #(.DWIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .PACK(PK),
                 .ADDR_WIDTH(AW), .BASE_ADDR(BASE_A)) dut_a (
    .clock(clk), .reset(rst_n), .start(start_a), .fifo_rd_en(rd_a), .fifo_dout(dout_a),
    .fifo_empty(empty_a), .mem_wr_en(wr_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_ready(ready_a), .busy(busy_a), .frame_done(done_a), .pix_x(px_a), .pix_y(py_a),
    .checksum(cs_a));

  frame_writer #(.DWIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3), .PACK(PK),
                 .ADDR_WIDTH(AW), .BASE_ADDR(BASE_B)) dut_b (
    .clock(clk), .reset(rst_n), .start(start_b), .fifo_rd_en(rd_b), .fifo_dout(dout_b),
    .fifo_empty(empty_b), .mem_wr_en(wr_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_ready(ready_b), .busy(busy_b), .frame_done(done_b), .pix_x(px_b), .pix_y(py_b),
    .checksum(cs_b));

  // First-word-fall-through FIFO models
  logic [DW-1:0] pa [0:255];
  logic [DW-1:0] pb [0:255];
  int pa_wr = 0, pa_rd = 0, pb_wr = 0, pb_rd = 0, pops_b = 0;

  assign empty_a = (pa_rd == pa_wr);
  assign dout_a  = pa[pa_rd[7:0]];
  assign empty_b = gap_b || (pb_rd == pb_wr);
  assign dout_b  = pb[pb_rd[7:0]];

  always @(posedge clk) begin
    if (rd_a && !empty_a) pa_rd <= pa_rd + 1;
    if (!rst_n) begin
      pb_rd <= pb_wr;
    end else if (rd_b && !empty_b) begin
      pb_rd  <= pb_rd + 1;
      pops_b <= pops_b + 1;
    end
  end

  // Write / pulse monitors: record every accepted write for the scoreboard
  logic [AW-1:0] obs_addr_a [0:63];
  logic [31:0]   obs_data_a [0:63];
  logic [AW-1:0] obs_addr_b [0:63];
  logic [31:0]   obs_data_b [0:63];
  int obs_n_a = 0, obs_n_b = 0, obs_rd_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    if (wr_a && ready_a) begin
      obs_addr_a[obs_n_a[5:0]] <= addr_a;
      obs_data_a[obs_n_a[5:0]] <= wdata_a;
      obs_n_a <= obs_n_a + 1;
    end
    if (wr_b && ready_b) begin
      obs_addr_b[obs_n_b[5:0]] <= addr_b;
      obs_data_b[obs_n_b[5:0]] <= wdata_b;
      obs_n_b <= obs_n_b + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  logic [AW-1:0] eb_addr [$];
  logic [31:0]   eb_data [$];
  logic [15:0]   exp_cs_b;

  task automatic load_b(input logic [7:0] first);
    logic [31:0] w;
    logic [7:0]  p;
    w = '0;
    exp_cs_b = '0;
    for (int i = 0; i < 9; i++) begin
      p = first + 8'(i);
      pb[pb_wr[7:0]] = p;
      pb_wr++;
      exp_cs_b += 16'(p);
      w[(i % 4) * 8 +: 8] = p;
      if ((i % 4 == 3) || (i == 8)) begin
        eb_addr.push_back(AW'(BASE_B + i / 4));
        eb_data.push_back(w);
        w = '0;
      end
    end
  endtask

  task automatic drain_b();
    while (obs_rd_b < obs_n_b) begin
      expect_eq("b_wr_expected", eb_addr.size() != 0, 1);
      if (eb_addr.size() != 0) begin
        expect_eq("b_addr", obs_addr_b[obs_rd_b[5:0]], eb_addr.pop_front());
        expect_eq("b_data", obs_data_b[obs_rd_b[5:0]], eb_data.pop_front());
      end
      obs_rd_b++;
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    @(posedge clk); #2;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #2;
      cyc++;
      seen = sel_b ? done_b : done_a;
    end
    expect_eq(sel_b ? "b_done_seen" : "a_done_seen", seen, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, p0, w0, d0;
    logic [31:0] word;
    bit seen;

    repeat (3) @(posedge clk); #2;
    expect_eq("rst_busy", busy_b, 0);
    expect_eq("rst_addr", addr_b, 0);
    expect_eq("rst_wdata", wdata_b, 0);
    expect_eq("rst_checksum", cs_b, 0);
    expect_eq("rst_pix", {px_b, py_b}, 0);
    rst_n = 1'b1;

    load_b(8'h10);
    repeat (3) @(posedge clk); #2;
    expect_eq("idle_no_pop", pops_b, 0);

    // 4x2 frame, pixels 1..8
    for (int i = 0; i < 8; i++) begin
      pa[pa_wr[7:0]] = 8'(i + 1);
      pa_wr++;
    end
    pulse_start(1'b0);
    expect_eq("a_busy_after_start", busy_a, 1);
    wait_done(1'b0, cyc);
    expect_eq("a_latency", cyc, 2 * (PK + 1));
    expect_eq("a_busy_in_done", busy_a, 1);
    expect_eq("a_checksum", cs_a, CSUM_ON ? 36 : 0);
    @(posedge clk); #2;
    expect_eq("a_busy_fall", busy_a, 0);
    repeat (3) @(posedge clk); #2;
    expect_eq("a_done_pulses", done_cnt_a, 1);
    expect_eq("a_word_count", obs_n_a, 2);
    expect_eq("a_addr0", obs_addr_a[0], BASE_A);
    expect_eq("a_data0", obs_data_a[0], 32'h04030201);
    expect_eq("a_addr1", obs_addr_a[1], BASE_A + 1);
    expect_eq("a_data1", obs_data_a[1], 32'h08070605);

    // 3x3 frame, pixels 0x10..0x18, partial last word
    pulse_start(1'b1);
    expect_eq("b_start_pix", {px_b, py_b}, 0);
    expect_eq("b_start_addr", addr_b, BASE_B);
    wait_done(1'b1, cyc);
    expect_eq("b_latency", cyc, 3 * (PK + 1) - 3);
    expect_eq("b_checksum", cs_b, CSUM_ON ? exp_cs_b : 0);
    repeat (3) @(posedge clk); #2;
    drain_b();
    expect_eq("b_word_count", obs_n_b, 3);
    expect_eq("b_missing_wr", eb_addr.size(), 0);
    expect_eq("b_pix_wrap", {px_b, py_b}, 0);
    expect_eq("b_checksum_hold", cs_b, CSUM_ON ? exp_cs_b : 0);

    // Memory stall on the first write
    word = {8'h23, 8'h22, 8'h21, 8'h20};
    ready_b = 1'b0;
    load_b(8'h20);
    pulse_start(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      seen = wr_b;
    end
    expect_eq("stall_wr_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      expect_eq("stall_wr_en", wr_b, 1);
      expect_eq("stall_addr", addr_b, BASE_B);
      expect_eq("stall_wdata", wdata_b, word);
      expect_eq("stall_no_pop", rd_b, 0);
      @(posedge clk); #2;
    end
    ready_b = 1'b1;
    wait_done(1'b1, cyc);
    repeat (2) @(posedge clk); #2;
    drain_b();
    expect_eq("stall_word_count", obs_n_b, 6);
    expect_eq("stall_missing_wr", eb_addr.size(), 0);

    // FIFO empty for 3 cycles mid-word
    load_b(8'h30);
    p0 = pops_b;
    pulse_start(1'b1);
    for (int i = 0; i < 20 && (pops_b - p0) < 2; i++) begin
      @(posedge clk); #2;
    end
    gap_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_eq("gap_no_pop", rd_b, 0);
      expect_eq("gap_no_write", wr_b, 0);
      @(posedge clk); #2;
    end
    expect_eq("gap_pop_count", pops_b - p0, 2);
    gap_b = 1'b0;
    wait_done(1'b1, cyc);
    repeat (2) @(posedge clk); #2;
    drain_b();
    expect_eq("gap_word_count", obs_n_b, 9);

    // Start pulsed mid-frame is ignored
    load_b(8'h40);
    pulse_start(1'b1);
    repeat (3) @(posedge clk); #2;
    start_b = 1'b1;
    @(posedge clk); #2;
    start_b = 1'b0;
    wait_done(1'b1, cyc);
    repeat (3) @(posedge clk); #2;
    drain_b();
    expect_eq("midstart_word_count", obs_n_b, 12);
    expect_eq("midstart_done_pulses", done_cnt_b, 4);

    // Reset after 5 pixels, then a fresh frame
    load_b(8'h50);
    p0 = pops_b;
    pulse_start(1'b1);
    for (int i = 0; i < 20 && (pops_b - p0) < 5; i++) begin
      @(posedge clk); #2;
    end
    expect_eq("pre_rst_pix_x", px_b, 2);
    expect_eq("pre_rst_pix_y", py_b, 1);
    d0 = done_cnt_b;
    rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_busy", busy_b, 0);
    expect_eq("mid_rst_wr_en", wr_b, 0);
    expect_eq("mid_rst_rd_en", rd_b, 0);
    expect_eq("mid_rst_addr", addr_b, 0);
    expect_eq("mid_rst_wdata", wdata_b, 0);
    expect_eq("mid_rst_pix", {px_b, py_b}, 0);
    expect_eq("mid_rst_checksum", cs_b, 0);
    drain_b();
    eb_addr.delete();
    eb_data.delete();
    w0 = obs_n_b;
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #2;
    expect_eq("rst_no_done", done_cnt_b, d0);
    expect_eq("rst_no_write", obs_n_b, w0);
    load_b(8'h60);
    pulse_start(1'b1);
    expect_eq("new_frame_pix", {px_b, py_b}, 0);
    expect_eq("new_frame_addr", addr_b, BASE_B);
    wait_done(1'b1, cyc);
    expect_eq("new_frame_checksum", cs_b, CSUM_ON ? exp_cs_b : 0);
    repeat (3) @(posedge clk); #2;
    drain_b();
    expect_eq("new_frame_words", obs_n_b - w0, 3);
    expect_eq("new_frame_missing_wr", eb_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
